video_timing_monitor: RTL
=========================

# video_timing_monitor

Downstream stage of the video processing unit: consumes its registered `{luma, chroma}` stream and `fvht` timing and passes both through unchanged with one enabled-cycle delay. Measures active pixels per line and active lines per field on the same stream. Declares lock once the measured format has been stable for a programmable number of fields, and flags format changes. Feeds the board status/debug registers and gates downstream consumers that need a stable raster.

## Interface
- `PIX_W`, 12: width of pixel-per-line counter and output.
- `LINE_W`, 11: width of line-per-field counter and output.
- `LOCK_FIELDS`, 2: consecutive matching consistent fields required for lock; legal range 1–15.
- `clk_i`  in  1  clock; one clock domain; reset is synchronous and active-high.
- `rst_i`  in  1  synchronous active-high reset.
- `cen_i`  in  1  clock enable; all state advances only on cycles with `cen_i`=1.
- `fvht_i`  in  4  timing: [3] F field id, [2] V vertical blank (1=blank), [1] H horizontal blank (1=blank), [0] T TRS marker (passed through, unused).
- `video_i`  in  20  video `{luma[19:10], chroma[9:0]}`.
- `fvht_o`  out  4  `fvht_i` delayed one enabled cycle.
- `video_o`  out  20  `video_i` delayed one enabled cycle.
- `pix_per_line_o`  out  PIX_W  active samples in the last consistent field's lines.
- `lines_per_field_o`  out  LINE_W  active lines in the last completed field.
- `field_o`  out  1  F value sampled at the last field end.
- `locked_o`  out  1  format stable.
- `err_o`  out  1  one-clock pulse on loss of lock.

## Operation
- Registered previous H and V (`h_q`, `v_q`), updated on enabled cycles. Edges are defined against them.
  - Line start: H 1→0 with V=0.
  - Line end: H 0→1 with `line_open`.
  - Field end: V 0→1.
- Pixel counter: cleared at line start, then +1 per enabled sample with H=0 and V=0, counting the start sample. Saturates at all-ones.
- Line end:
  - Latch the count into `cur_len`.
  - Increment the line counter (saturating).
  - The first line of the field sets `field_len`. Any later line with `cur_len`≠`field_len` clears the `consistent` flag.
- If a line is still open at field end (H and V edges on the same sample), the line is closed first and then the field, so the final line is counted.
- Lines in which H never falls while V=0 are not counted.
- At field end, `lines_per_field_o`/`field_o` load. `pix_per_line_o` loads `field_len` if the field is consistent. The line counter and `consistent` then reset for the next field.
- A field with zero active lines is inconsistent.
- FSM, evaluated at field end only:
  - SEARCH: first field end discards the partial field → MEASURE, `match_cnt`=0.
  - MEASURE:
    - Consistent field equal to reference (`field_len`, line count) → `match_cnt`+1.
    - Consistent field not equal → reference := current, `match_cnt`=1.
    - Inconsistent field → `match_cnt`=0.
    - When `match_cnt` reaches `LOCK_FIELDS` → LOCKED.
  - LOCKED: matching consistent field → stay. Any other field → `err_o` pulse, MEASURE, with reference and `match_cnt` loaded as for a non-matching field.
- `locked_o` = (state==LOCKED), registered.

## Timing
- Pass-through latency: exactly 1 enabled cycle. Outputs hold while `cen_i`=0.
- Measurement outputs and `locked_o` change on the clock edge that registers the field-end sample, i.e. in the same cycle `fvht_o[2]` first shows 1.
- `err_o` is high for exactly one clock (not one enabled cycle) at that edge.
- `rst_i` on any edge, overriding `cen_i`:
  - All outputs, counters, reference and `match_cnt` go to 0; state → SEARCH.
  - `h_q` and `v_q` go to 1, so no edge is detected on the first post-reset sample.
- Reset mid-field: the partial field is discarded via SEARCH.
- `cen_i`=0 cycles are invisible: the stream is counted as if they were absent.

## Test plan
- Reset, then 4 fields of 720 active samples × 243 active lines, `LOCK_FIELDS`=2 → `locked_o` rises at the 3rd field end. Outputs: `pix_per_line_o`=720, `lines_per_field_o`=243, `err_o` stays 0.
- `cen_i` toggled 1-0 through the same stream → identical results. `video_o`/`fvht_o` equal the input one enabled sample later.
- While locked, one field has line 100 with 719 samples → at that field end `err_o` pulses once and `locked_o`=0. Two subsequent good fields → relock. `pix_per_line_o` holds 720 throughout.
- Format switches from 720×243 to 720×288 while locked → error pulse, then relock after 1 more 288-line field (reference reloaded, count starts at 1). `lines_per_field_o`=288.
- Final line's H rising edge coincides with the V rising edge → `lines_per_field_o`=243, not 242.
- `rst_i` asserted for 1 cycle at line 50 of a locked stream → all outputs 0 the next cycle. `locked_o` returns after 3 field ends.

Source files
------------

// File: rtl/video_timing_monitor.sv
// Pass-through stage that measures active raster size per field and declares lock
// once the measured format has repeated for LOCK_FIELDS consistent fields.
module video_timing_monitor #(
    parameter int PIX_W       = 12,
    parameter int LINE_W      = 11,
    parameter int LOCK_FIELDS = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cen_i,
    input  logic [3:0]        fvht_i,
    input  logic [19:0]       video_i,
    output logic [3:0]        fvht_o,
    output logic [19:0]       video_o,
    output logic [PIX_W-1:0]  pix_per_line_o,
    output logic [LINE_W-1:0] lines_per_field_o,
    output logic              field_o,
    output logic              locked_o,
    output logic              err_o
);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_FIELDS);

    state_t              state;
    logic                h_q, v_q;
    logic                line_open;
    logic [PIX_W-1:0]    pix_cnt;
    logic [LINE_W-1:0]   line_cnt;
    logic [PIX_W-1:0]    field_len;
    logic                consistent;
    logic [PIX_W-1:0]    ref_len;
    logic [LINE_W-1:0]   ref_lines;
    logic [3:0]          match_cnt;

    logic                h, v;
    logic                line_start, line_end, field_end;
    logic [LINE_W-1:0]   line_cnt_nx;
    logic [PIX_W-1:0]    field_len_nx;
    logic                consistent_nx;
    logic                field_ok, field_match;
    logic [3:0]          match_nx;

    assign h          = fvht_i[1];
    assign v          = fvht_i[2];
    assign line_start = h_q & ~h & ~v;
    assign line_end   = ~h_q & h & line_open;
    assign field_end  = ~v_q & v;

    // Line closure is resolved first so a line ending on the field-end sample still counts.
    always_comb begin
        line_cnt_nx   = line_cnt;
        field_len_nx  = field_len;
        consistent_nx = consistent;
        if (line_end) begin
            line_cnt_nx = (&line_cnt) ? line_cnt : line_cnt + 1'b1;
            if (line_cnt == '0)
                field_len_nx = pix_cnt;
            else if (pix_cnt != field_len)
                consistent_nx = 1'b0;
        end
        field_ok    = consistent_nx && (line_cnt_nx != '0);
        field_match = field_ok && (field_len_nx == ref_len) && (line_cnt_nx == ref_lines);
        if (!field_ok)
            match_nx = 4'd0;
        else if (field_match)
            match_nx = match_cnt + 4'd1;
        else
            match_nx = 4'd1;
    end

    always_ff @(posedge clk_i) begin
        err_o <= 1'b0;
        if (rst_i) begin
            fvht_o            <= '0;
            video_o           <= '0;
            pix_per_line_o    <= '0;
            lines_per_field_o <= '0;
            field_o           <= 1'b0;
            locked_o          <= 1'b0;
            h_q               <= 1'b1;
            v_q               <= 1'b1;
            line_open         <= 1'b0;
            pix_cnt           <= '0;
            line_cnt          <= '0;
            field_len         <= '0;
            consistent        <= 1'b1;
            ref_len           <= '0;
            ref_lines         <= '0;
            match_cnt         <= 4'd0;
            state             <= SEARCH;
        end else if (cen_i) begin
            fvht_o  <= fvht_i;
            video_o <= video_i;
            h_q     <= h;
            v_q     <= v;

            if (line_start) begin
                pix_cnt   <= PIX_W'(1);
                line_open <= 1'b1;
            end else if (line_open && !h && !v && !(&pix_cnt)) begin
                pix_cnt <= pix_cnt + 1'b1;
            end
            if (line_end)
                line_open <= 1'b0;

            if (field_end) begin
                line_open         <= 1'b0;
                lines_per_field_o <= line_cnt_nx;
                field_o           <= fvht_i[3];
                if (field_ok)
                    pix_per_line_o <= field_len_nx;
                line_cnt   <= '0;
                field_len  <= '0;
                consistent <= 1'b1;

                if (field_ok && !field_match) begin
                    ref_len   <= field_len_nx;
                    ref_lines <= line_cnt_nx;
                end

                case (state)
                    SEARCH: begin
                        state     <= MEASURE;
                        match_cnt <= 4'd0;
                    end
                    MEASURE: begin
                        match_cnt <= match_nx;
                        if (match_nx >= LOCK_N) begin
                            state    <= LOCKED;
                            locked_o <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (!field_match) begin
                            err_o     <= 1'b1;
                            locked_o  <= 1'b0;
                            state     <= MEASURE;
                            match_cnt <= match_nx;
                        end
                    end
                    default: begin
                        state     <= SEARCH;
                        locked_o  <= 1'b0;
                        match_cnt <= 4'd0;
                    end
                endcase
            end else begin
                line_cnt   <= line_cnt_nx;
                field_len  <= field_len_nx;
                consistent <= consistent_nx;
            end
        end
    end

endmodule
